// File: rtl/restoring_divider_if.sv
// restoring_divider_if: request/result handshake bundle for the restoring divider
interface restoring_divider_if #(
   parameter int N = 4
);
   logic         start_i;
   logic [N-1:0] dividend_i;
   logic [N-1:0] divisor_i;
   logic         ready_o;
   logic         valid_o;
   logic [N-1:0] quotient_o;
   logic [N-1:0] remainder_o;
   logic         div_by_zero_o;
   modport slave (
      input  start_i, dividend_i, divisor_i,
      output ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o
   );
   modport master (
      output start_i, dividend_i, divisor_i,
      input  ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o
   );
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per cycle
module restoring_divider #(
   parameter int N = 4
) (
   input logic             clk_i,
   input logic             rst_i,
   restoring_divider_if.slave bus
);
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t        r_state;
   state_t        w_next;
   logic          w_ready;
   logic          w_valid;
   logic [N-1:0]  r_dvd;
   logic [N-1:0]  r_dvs;
   logic [N-1:0]  r_rem;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_q;
   logic [N-1:0]  r_r;
   logic          r_dz;
   logic          w_dz;
   logic          w_last;
   logic          w_ge;
   logic [N:0]    w_shift;
   logic [N:0]    w_diff;
   logic [N-1:0]  w_rem_nxt;
   logic [N-1:0]  w_dvd_nxt;
   assign w_dz      = (bus.divisor_i == '0);
   assign w_last    = (r_cnt == CW'(N - 1));
   // The remainder is always below the divisor, so the shifted value fits N+1 bits
   // and the sign of the N+1-bit difference is exactly its top bit.
   assign w_shift   = {r_rem, r_dvd[N-1]};
   assign w_diff    = w_shift - {1'b0, r_dvs};
   assign w_ge      = ~w_diff[N];
   assign w_rem_nxt = w_ge ? w_diff[N-1:0] : w_shift[N-1:0];
   assign w_dvd_nxt = {r_dvd[N-2:0], w_ge};
   assign bus.ready_o       = w_ready;
   assign bus.valid_o       = w_valid;
   assign bus.quotient_o    = r_q;
   assign bus.remainder_o   = r_r;
   assign bus.div_by_zero_o = r_dz;
   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // Next state and handshake outputs; a zero divisor skips CALC entirely
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_valid = 1'b0;
      w_next  = (r_state == IDLE) ? (bus.start_i ? (w_dz ? DONE : CALC) : IDLE) :
                (r_state == CALC) ? (w_last ? DONE : CALC) : IDLE;
      w_ready = (r_state == IDLE);
      w_valid = (r_state == DONE);
   end
   // Operand capture, iteration datapath and result registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_dvd <= '0;
         r_dvs <= '0;
         r_rem <= '0;
         r_cnt <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_dz  <= 1'b0;
      end else if (r_state == IDLE && bus.start_i) begin
         r_dvd <= bus.dividend_i;
         r_dvs <= bus.divisor_i;
         r_rem <= '0;
         r_cnt <= '0;
         if (w_dz) begin
            r_q  <= '1;
            r_r  <= bus.dividend_i;
            r_dz <= 1'b1;
         end
      end else if (r_state == CALC) begin
         r_dvd <= w_dvd_nxt;
         r_rem <= w_rem_nxt;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_q  <= w_dvd_nxt;
            r_r  <= w_rem_nxt;
            r_dz <= 1'b0;
         end
      end
   end
endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter N, default 4, operand width in bits; the design SHALL support any N >= 2.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  request to begin a division; the request is sampled only while ready_o=1.
REQ-005 dividend_i  input  N  unsigned dividend; captured on the accepting edge.
REQ-006 divisor_i  input  N  unsigned divisor; captured on the accepting edge.
REQ-007 ready_o  output  1  high while the block is idle and able to accept start_i.
REQ-008 valid_o  output  1  single-cycle pulse marking quotient_o and remainder_o as new results.
REQ-009 quotient_o  output  N  unsigned quotient, registered.
REQ-010 remainder_o  output  N  unsigned remainder, registered.
REQ-011 div_by_zero_o  output  1  flag qualifying the current result; registered with the results.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-013 In IDLE, start_i=1 on an edge SHALL be the accepting edge E0; on E0 the block SHALL latch both operands, and the remainder accumulator and the iteration counter SHALL be cleared.
REQ-014 On E0 with a nonzero divisor, the FSM SHALL move IDLE->CALC.
REQ-015 On E0 with divisor=0, the FSM SHALL move IDLE->DONE directly, with no CALC cycles.
REQ-016 Each edge in CALC SHALL perform one restoring step:
  - shift {remainder, dividend} left by 1;
  - compute a trial subtraction of (N+1)-bit remainder minus divisor;
  - if the result is non-negative, the remainder SHALL take the difference and the quotient bit SHALL be 1;
  - otherwise the remainder SHALL be kept (restored) and the quotient bit SHALL be 0.
REQ-017 The trial subtraction SHALL use N+1 bits so that no overflow occurs for any operands.
REQ-018 CALC SHALL last exactly N edges (E1..EN), counted by a ceil(log2(N+1))-bit counter; on EN the FSM SHALL move CALC->DONE and the final results SHALL be loaded into quotient_o and remainder_o.
REQ-019 valid_o SHALL be 1 only while in DONE.
  - Normal division: valid_o SHALL be high in the cycle following EN, which is N edges after E0.
  - Divide-by-zero: valid_o SHALL be high in the cycle following E0.
REQ-020 DONE SHALL last exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-021 ready_o SHALL be 1 only in IDLE, so it is low from the cycle after E0 through the DONE cycle inclusive.
REQ-022 start_i SHALL be ignored in CALC and DONE; no request is queued.
REQ-023 A start_i held high continuously SHALL produce back-to-back operations with exactly one IDLE cycle between them.
REQ-024 Changes on dividend_i or divisor_i after E0 SHALL NOT affect the operation in flight.
REQ-025 quotient_o, remainder_o and div_by_zero_o SHALL hold their last values until the next DONE entry.
REQ-026 On a divide-by-zero:
  - quotient_o SHALL be all ones (2^N-1);
  - remainder_o SHALL equal the dividend;
  - div_by_zero_o SHALL be 1.
REQ-027 On a normal division, div_by_zero_o SHALL be 0.
REQ-028 For every nonzero divisor, the results SHALL satisfy quotient*divisor + remainder = dividend, with remainder < divisor.
REQ-029 quotient_o and remainder_o SHALL NOT change outside the DONE-entry edge.
REQ-030 Dividend 0 SHALL take the normal path and yield quotient 0 and remainder 0.

Reset
REQ-031 rst_i=1 on an edge SHALL force IDLE and SHALL take priority over start_i and over all FSM transitions.
REQ-032 The reset values SHALL be: ready_o=1 (from the cycle after the reset edge), valid_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0, counter=0, operand registers=0.
REQ-033 A reset during CALC or DONE SHALL abort the operation; no valid_o pulse SHALL follow for the aborted operation.

Verification
REQ-034 The bench SHALL cover the following directed scenarios, with N=4 unless stated otherwise:
  - Basic division: dividend 13, divisor 3 -> valid_o 4 edges after E0, quotient 4, remainder 1, div_by_zero_o 0.
  - Small dividend: dividend 2, divisor 9 -> quotient 0, remainder 2.
  - Divisor of one: dividend 15, divisor 1 -> quotient 15, remainder 0.
  - Divide by zero: dividend 7, divisor 0 -> valid_o 1 edge after E0, quotient 15, remainder 7, div_by_zero_o 1.
  - Reset mid-operation: start 13/3, assert rst_i at E2 -> no valid_o pulse, ready_o=1, all outputs 0.
    - Then start 9/2 -> quotient 4, remainder 1.
  - Back-to-back with exhaustive check: start_i held high; operand pairs changed every cycle -> one result per N+2 cycles.
    - All 256 operand pairs checked against REQ-026/REQ-028.
    - quotient*divisor is cross-checked using array_multiplier.
